// File: rtl/iq_lockin_demod.sv
// Multi-channel quadrature lock-in demodulator: square-wave I/Q mixing per channel,
// integrate-and-dump decimation by DECIM, and a first-word-fall-through output FIFO.
module iq_lockin_demod #(
  parameter int DW         = 24,
  parameter int NCH        = 4,
  parameter int PHW        = 16,
  parameter int DECIM      = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  input  logic signed [DW-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [CW-1:0]        s_axis_tuser,
  input  logic [PHW-1:0]       phase_inc,
  output logic [2*DW-1:0]      m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [CW-1:0]        m_axis_tuser
);

  localparam int LD  = $clog2(DECIM);
  localparam int AW  = DW + LD + 1;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = 2*DW + CW;

  logic                 aresetn_q;
  logic [PHW-1:0]       phAcc_q   [NCH];
  logic [PHW-1:0]       phAcc_d   [NCH];
  logic signed [AW-1:0] accI_q    [NCH];
  logic signed [AW-1:0] accI_d    [NCH];
  logic signed [AW-1:0] accQ_q    [NCH];
  logic signed [AW-1:0] accQ_d    [NCH];
  logic [LD-1:0]        sampCnt_q [NCH];
  logic [LD-1:0]        sampCnt_d [NCH];

  logic                 s1Valid_q, s1Valid_d;
  logic signed [DW-1:0] s1Data_q, s1Data_d;
  logic [CW-1:0]        s1Ch_q, s1Ch_d;
  logic                 s1INeg_q, s1INeg_d;
  logic                 s1QNeg_q, s1QNeg_d;

  logic [OW-1:0]        fifoMem_q [FIFO_DEPTH];
  logic [FAW-1:0]       rdPtr_q, rdPtr_d;
  logic [FAW-1:0]       wrPtr_q, wrPtr_d;
  logic [FCW-1:0]       fifoCnt_q, fifoCnt_d;

  logic                 accept, chValid, dumpHit, push, pop;
  logic [PHW-1:0]       inPhase;
  logic signed [AW-1:0] xExt, mixI, mixQ, sumI, sumQ;
  logic [OW-1:0]        dumpWord;

  // Holding back two slots covers the stage-1 sample plus the dump already in flight.
  assign s_axis_tready = aresetn_q && (fifoCnt_q <= FCW'(FIFO_DEPTH - 3));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign chValid       = accept && ({1'b0, s_axis_tuser} < (CW+1)'(NCH));
  assign inPhase       = phAcc_q[s_axis_tuser];

  assign xExt     = {{(AW-DW){s1Data_q[DW-1]}}, s1Data_q};
  assign mixI     = s1INeg_q ? -xExt : xExt;
  assign mixQ     = s1QNeg_q ? -xExt : xExt;
  assign sumI     = accI_q[s1Ch_q] + mixI;
  assign sumQ     = accQ_q[s1Ch_q] + mixQ;
  assign dumpHit  = s1Valid_q && (sampCnt_q[s1Ch_q] == LD'(DECIM - 1));
  assign dumpWord = {s1Ch_q, DW'(sumQ >>> LD), DW'(sumI >>> LD)};
  assign push     = dumpHit;
  assign pop      = (fifoCnt_q != '0) && m_axis_tready;

  always_comb begin
    phAcc_d   = phAcc_q;
    accI_d    = accI_q;
    accQ_d    = accQ_q;
    sampCnt_d = sampCnt_q;
    s1Valid_d = chValid;
    s1Data_d  = s_axis_tdata;
    s1Ch_d    = s_axis_tuser;
    s1INeg_d  = inPhase[PHW-1] ^ inPhase[PHW-2];
    s1QNeg_d  = inPhase[PHW-1];
    if (chValid) begin
      phAcc_d[s_axis_tuser] = inPhase + phase_inc;
    end
    if (s1Valid_q) begin
      if (dumpHit) begin
        accI_d[s1Ch_q]    = '0;
        accQ_d[s1Ch_q]    = '0;
        sampCnt_d[s1Ch_q] = '0;
      end else begin
        accI_d[s1Ch_q]    = sumI;
        accQ_d[s1Ch_q]    = sumQ;
        sampCnt_d[s1Ch_q] = sampCnt_q[s1Ch_q] + 1'b1;
      end
    end
  end

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    fifoCnt_d = fifoCnt_q;
    if (push) begin
      wrPtr_d = (wrPtr_q == FAW'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = (rdPtr_q == FAW'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifoCnt_d = fifoCnt_q + 1'b1;
      2'b01:   fifoCnt_d = fifoCnt_q - 1'b1;
      default: fifoCnt_d = fifoCnt_q;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      aresetn_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        phAcc_q[c]   <= '0;
        accI_q[c]    <= '0;
        accQ_q[c]    <= '0;
        sampCnt_q[c] <= '0;
      end
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s1Ch_q    <= '0;
      s1INeg_q  <= 1'b0;
      s1QNeg_q  <= 1'b0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      aresetn_q <= 1'b1;
      phAcc_q   <= phAcc_d;
      accI_q    <= accI_d;
      accQ_q    <= accQ_d;
      sampCnt_q <= sampCnt_d;
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s1Ch_q    <= s1Ch_d;
      s1INeg_q  <= s1INeg_d;
      s1QNeg_q  <= s1QNeg_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      fifoCnt_q <= fifoCnt_d;
    end
  end

  // Storage needs no reset: the read side is gated by the occupancy count.
  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      fifoMem_q[wrPtr_q] <= dumpWord;
    end
  end

  assign m_axis_tvalid = (fifoCnt_q != '0);
  assign {m_axis_tuser, m_axis_tdata} = m_axis_tvalid ? fifoMem_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_iq_lockin_demod.sv
// Randomized and directed bench for iq_lockin_demod, checked against a per-channel
// quadrant/average reference model and a queue of expected output words.
module tb_iq_lockin_demod;

  localparam int DW         = 24;
  localparam int NCH        = 4;
  localparam int PHW        = 16;
  localparam int DECIM      = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = 2;
  localparam int OW         = 2*DW + CW;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic signed [DW-1:0] sData;
  logic                 sValid;
  logic                 sReady;
  logic [CW-1:0]        sUser;
  logic [PHW-1:0]       pInc;
  logic [2*DW-1:0]      mData;
  logic                 mValid;
  logic                 mReady;
  logic [CW-1:0]        mUser;

  always #5 clk = ~clk;

  iq_lockin_demod #(
    .DW(DW), .NCH(NCH), .PHW(PHW), .DECIM(DECIM), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_aresetn(aresetn),
    .s_axis_tdata(sData),
    .s_axis_tvalid(sValid),
    .s_axis_tready(sReady),
    .s_axis_tuser(sUser),
    .phase_inc(pInc),
    .m_axis_tdata(mData),
    .m_axis_tvalid(mValid),
    .m_axis_tready(mReady),
    .m_axis_tuser(mUser)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] mkWord(input int ch, input int q, input int i);
    return {CW'(ch), DW'(q), DW'(i)};
  endfunction

  function automatic longint floorDiv(input longint s);
    longint r;
    r = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) r = r - 1;
    return r;
  endfunction

  function automatic int rndSample();
    return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
  endfunction

  // Reference model: quadrant of each channel's phase picks the +/-1 references.
  logic [PHW-1:0] mPh   [NCH];
  longint         mSumI [NCH];
  longint         mSumQ [NCH];
  int             mCnt  [NCH];
  logic [OW-1:0]  expQ  [$];
  logic [OW-1:0]  gotQ  [$];
  int             mc, quad, iRef, qRef;

  always @(negedge clk) begin
    if (!aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        mPh[c] = '0; mSumI[c] = 0; mSumQ[c] = 0; mCnt[c] = 0;
      end
      expQ.delete();
    end else begin
      if (mValid && mReady) begin
        gotQ.push_back({mUser, mData});
        if (expQ.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL word: got %h expected no word", {mUser, mData});
        end else begin
          checkOutput("word", {mUser, mData}, expQ.pop_front());
        end
      end
      if (sValid && sReady && int'(sUser) < NCH) begin
        mc   = int'(sUser);
        quad = int'(mPh[mc]) / (1 << (PHW - 2));
        iRef = (quad == 0 || quad == 3) ? 1 : -1;
        qRef = (quad < 2) ? 1 : -1;
        mSumI[mc] += iRef * longint'(sData);
        mSumQ[mc] += qRef * longint'(sData);
        mPh[mc] = mPh[mc] + pInc;
        mCnt[mc]++;
        if (mCnt[mc] == DECIM) begin
          expQ.push_back(mkWord(mc, int'(floorDiv(mSumQ[mc])), int'(floorDiv(mSumI[mc]))));
          mSumI[mc] = 0; mSumQ[mc] = 0; mCnt[mc] = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input int ch, input int data, input logic [PHW-1:0] pinc);
    bit hs;
    int waited;
    sUser  = CW'(ch);
    sData  = DW'(data);
    pInc   = pinc;
    sValid = 1'b1;
    hs     = 0;
    waited = 0;
    while (!hs && waited < 200) begin
      @(negedge clk);
      hs = sReady;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!hs) begin
      vectors++;
      errors++;
      $display("[TB] FAIL accept: got no handshake expected one within 200 cycles");
    end
  endtask

  task automatic waitDrain(input string tag);
    int w;
    sValid = 1'b0;
    mReady = 1'b1;
    w = 0;
    repeat (3) @(posedge clk);
    #1;
    while ((expQ.size() != 0 || mValid) && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 3000) begin
      vectors++;
      errors++;
      $display("[TB] FAIL %s drain: got %0d words pending expected 0", tag, expQ.size());
    end
  endtask

  initial begin
    int vals [4];
    bit hs;
    vals = '{100, 200, 300, -400};
    aresetn = 1'b0; sValid = 1'b0; sData = '0; sUser = '0; pInc = '0; mReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst mvalid", mValid, 0);
    checkOutput("rst sready", sReady, 0);
    checkOutput("rst mdata", mData, 0);
    checkOutput("rst muser", mUser, 0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // DC input with latency check
    for (int i = 0; i < DECIM; i++) applyStimulus(0, 1000, '0);
    sValid = 1'b0;
    checkOutput("t1 lat1", mValid, 0);
    @(posedge clk);
    #1;
    checkOutput("t1 lat2", mValid, 1);
    checkOutput("t1 word", {mUser, mData}, mkWord(0, 1000, 1000));
    gotQ.delete();
    waitDrain("t1");

    // Quadrature input
    gotQ.delete();
    for (int i = 0; i < DECIM; i++) applyStimulus(0, ((i % 4) < 2) ? 1000 : -1000, 16'h4000);
    waitDrain("t2");
    checkOutput("t2 count", gotQ.size(), 1);
    checkOutput("t2 word", gotQ[0], mkWord(0, 1000, 0));

    // Interleaved channels
    gotQ.delete();
    for (int i = 0; i < 4*DECIM; i++) applyStimulus(i % 4, vals[i % 4], '0);
    waitDrain("t3");
    checkOutput("t3 count", gotQ.size(), 4);
    for (int c = 0; c < 4; c++) checkOutput("t3 word", gotQ[c], mkWord(c, vals[c], vals[c]));

    // Floor rounding
    gotQ.delete();
    for (int i = 0; i < DECIM; i++) applyStimulus(0, i % 2, '0);
    for (int i = 0; i < DECIM; i++) applyStimulus(0, -(i % 2), '0);
    waitDrain("t4");
    checkOutput("t4 count", gotQ.size(), 2);
    checkOutput("t4 pos", gotQ[0], mkWord(0, 0, 0));
    checkOutput("t4 neg", gotQ[1], mkWord(0, -1, -1));

    // Long output stall then random backpressure
    mReady = 1'b0; sUser = '0; pInc = '0; sValid = 1'b1; sData = DW'(rndSample());
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      hs = sReady;
      @(posedge clk);
      #1;
      if (hs) sData = DW'(rndSample());
    end
    checkOutput("t5 sready", sReady, 0);
    checkOutput("t5 mvalid", mValid, 1);
    checkOutput("t5 queued", expQ.size(), 6);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      mReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = sReady;
      @(posedge clk);
      #1;
      if (hs) sData = DW'(rndSample());
    end
    waitDrain("t5");
    checkOutput("t5 left", expQ.size(), 0);

    // Reset in the middle of a block
    for (int i = 0; i < 30; i++) applyStimulus(0, 7, '0);
    sValid  = 1'b0;
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6 mvalid", mValid, 0);
    checkOutput("t6 sready", sReady, 0);
    aresetn = 1'b1;
    gotQ.delete();
    for (int i = 0; i < DECIM; i++) applyStimulus(0, 500, '0);
    waitDrain("t6");
    checkOutput("t6 count", gotQ.size(), 1);
    checkOutput("t6 word", gotQ[0], mkWord(0, 500, 500));

    // Fully random traffic across channels and phase steps
    for (int cyc = 0; cyc < 4000; cyc++) begin
      sValid = ($urandom_range(0, 3) != 0);
      sUser  = CW'($urandom_range(0, NCH - 1));
      sData  = DW'(rndSample());
      if ($urandom_range(0, 15) == 0) pInc = PHW'($urandom);
      mReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    waitDrain("t7");
    checkOutput("t7 left", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
